// File: rtl/des_round_ctrl.sv
// Sequencing controller for the iterative DES core: load/round/final strobes, key-rotation schedule, output handshake.
// Optional 3DES EDE sequencing is enabled by defining DES_TRIPLE_EN.
module des_round_ctrl #(
  parameter int unsigned ROUND_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             i_in_valid,
  input  logic             i_decrypt,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_dp_load,
  output logic             o_dp_round,
  output logic [1:0]       o_dp_shift,
  output logic             o_dp_dir,
  output logic [3:0]       o_dp_round_idx,
  output logic             o_dp_final,
  output logic [1:0]       o_key_sel,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_blocks_done
);

  localparam int unsigned SUB_W = 2;
  localparam int unsigned RND_W = 4;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(ROUND_CYCLES - 1);
`ifdef DES_TRIPLE_EN
  localparam logic [1:0] LAST_PASS = 2'd2;
`else
  localparam logic [1:0] LAST_PASS = 2'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               dec_q, dec_d;
  logic [1:0]         pass_q, pass_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               load_q, load_d;
  logic               rnd_q, rnd_d;
  logic               final_q, final_d;
  logic [1:0]         shift_q, shift_d;
  logic               dir_q, dir_d;
  logic [1:0]         key_sel_q, key_sel_d;
  logic               busy_q, busy_d;
  logic               op_dec;
  logic [1:0]         key_slot;

  // Key-schedule rotation: decrypt starts from the fully rotated key, so round 0 needs no shift.
  function automatic logic [1:0] shift_amt(input logic [RND_W-1:0] rnd, input logic dec);
    if (dec && rnd == 4'd0)                                          return 2'd0;
    else if (rnd == 4'd0 || rnd == 4'd1 || rnd == 4'd8 || rnd == 4'd15) return 2'd1;
    else                                                             return 2'd2;
  endfunction

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    round_d = round_q;
    dec_d   = dec_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_in_valid) begin
          state_d = S_LOAD;
          dec_d   = i_decrypt;
          pass_d  = 2'd0;
        end
      end
      S_LOAD: begin
        state_d = S_ROUND;
        round_d = 4'd0;
        sub_d   = '0;
      end
      S_ROUND: begin
        if (sub_q == SUB_LAST) begin
          sub_d   = '0;
          round_d = round_q + 4'd1;
          if (round_q == 4'd15) state_d = S_FINAL;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      S_FINAL: begin
        if (pass_q == LAST_PASS) begin
          state_d = S_DONE;
          cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          pass_d  = pass_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (i_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // EDE: the middle pass runs the opposite operation; decrypt walks the keys in reverse.
`ifdef DES_TRIPLE_EN
    op_dec   = dec_d ^ (pass_d == 2'd1);
    key_slot = dec_d ? (2'd2 - pass_d) : pass_d;
`else
    op_dec   = dec_d;
    key_slot = 2'd0;
`endif

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    load_d      = (state_d == S_LOAD);
    final_d     = (state_d == S_FINAL);
    rnd_d       = (state_d == S_ROUND) && (sub_d == SUB_LAST);
    shift_d     = rnd_d ? shift_amt(round_d, op_dec) : 2'd0;
    dir_d       = busy_d ? op_dec : 1'b0;
    key_sel_d   = busy_d ? key_slot : 2'd0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      sub_q       <= '0;
      round_q     <= '0;
      dec_q       <= 1'b0;
      pass_q      <= 2'd0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      rnd_q       <= 1'b0;
      final_q     <= 1'b0;
      shift_q     <= 2'd0;
      dir_q       <= 1'b0;
      key_sel_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      round_q     <= round_d;
      dec_q       <= dec_d;
      pass_q      <= pass_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      rnd_q       <= rnd_d;
      final_q     <= final_d;
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      key_sel_q   <= key_sel_d;
    end
  end

  assign o_in_ready     = in_ready_q;
  assign o_out_valid    = out_valid_q;
  assign o_busy         = busy_q;
  assign o_dp_load      = load_q;
  assign o_dp_round     = rnd_q;
  assign o_dp_final     = final_q;
  assign o_dp_shift     = shift_q;
  assign o_dp_dir       = dir_q;
  assign o_dp_round_idx = round_q;
  assign o_key_sel      = key_sel_q;
  assign o_blocks_done  = cnt_q;

endmodule
